// File: rtl/match_controller_pkg.sv
// Shared game definitions: match state encoding, winner codes and timer width.
// Imported by the match controller as well as the movement and rendering logic.
package match_controller_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        PAUSED    = 3'd3,
        KO_PAUSE  = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int TIMER_W = 10;

    // Winner from the two stock counts at the moment the match ends.
    function automatic logic [1:0] winner_code(input logic [1:0] stocks_a,
                                               input logic [1:0] stocks_b);
        logic [1:0] out_s;
        case ({stocks_a == 2'd0, stocks_b == 2'd0})
            2'b11:   out_s = WIN_DRAW;
            2'b01:   out_s = WIN_P1;
            2'b10:   out_s = WIN_P2;
            default: out_s = WIN_NONE;
        endcase
        return out_s;
    endfunction

endpackage

// File: rtl/match_controller_frame_timer.sv
// Loadable 10-bit frame down-counter with zero flag; a tick arriving with a
// load is counted against the freshly loaded value.
import match_controller_pkg::*;

module frame_timer (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               tick,
    output logic               zero
);

    logic [TIMER_W-1:0] count_r;

    // Counter register: load wins over decrement, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 10'd0;
        end else if (load) begin
            if (tick && (load_value != 10'd0)) begin
                count_r <= load_value - 10'd1;
            end else begin
                count_r <= load_value;
            end
        end else if (tick && (count_r != 10'd0)) begin
            count_r <= count_r - 10'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 10'd0);

endmodule

// File: rtl/match_controller.sv
// Match flow controller: title, countdown, fight, pause, KO freeze and game over,
// with all outputs registered.
import match_controller_pkg::*;

module match_controller #(
    parameter int SEC_FRAMES = 60,
    parameter int KO_FRAMES  = 90,
    parameter int GO_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start1,
    input  logic       start2,
    input  logic [1:0] stocks1,
    input  logic [1:0] stocks2,
    input  logic       respawn1,
    input  logic       respawn2,
    output logic [2:0] game_state,
    output logic       play_enable,
    output logic       match_reset,
    output logic [1:0] countdown_digit,
    output logic [1:0] winner
);

    localparam logic [TIMER_W-1:0] SEC_LOAD = 10'(SEC_FRAMES);
    localparam logic [TIMER_W-1:0] KO_LOAD  = 10'(KO_FRAMES);
    localparam logic [TIMER_W-1:0] GO_LOAD  = 10'(GO_FRAMES);

    game_state_t        state_r, state_next_s;
    logic               play_enable_r, match_reset_r, match_reset_next_s;
    logic [1:0]         digit_r, digit_next_s, winner_r, winner_next_s;
    logic               start1_prev_r, start2_prev_r, start_edge_s;
    logic               timer_load_s, timer_tick_s, timer_zero_s, stock_out_s;
    logic [TIMER_W-1:0] timer_value_s;

    assign start_edge_s = (start1 & ~start1_prev_r) | (start2 & ~start2_prev_r);
    assign stock_out_s  = (stocks1 == 2'd0) || (stocks2 == 2'd0);

    // A tick survives a state change only if the new state reloads the timer.
    assign timer_tick_s = frame_tick &&
                          (timer_load_s ||
                           ((state_next_s == state_r) &&
                            (state_r inside {COUNTDOWN, KO_PAUSE, GAME_OVER})));

    frame_timer u_frame_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .tick       (timer_tick_s),
        .zero       (timer_zero_s)
    );

    // Next-state, timer load and next-output decode.
    always_comb begin
        state_next_s       = state_r;
        digit_next_s       = digit_r;
        winner_next_s      = winner_r;
        match_reset_next_s = 1'b0;
        timer_load_s       = 1'b0;
        timer_value_s      = 10'd0;
        case (state_r)
            TITLE: begin
                if (start_edge_s) begin
                    state_next_s       = COUNTDOWN;
                    match_reset_next_s = 1'b1;
                    digit_next_s       = 2'd3;
                    timer_load_s       = 1'b1;
                    timer_value_s      = SEC_LOAD;
                end else begin
                    state_next_s = TITLE;
                end
            end
            COUNTDOWN: begin
                if (timer_zero_s) begin
                    if (digit_r == 2'd1) begin
                        state_next_s = FIGHT;
                        digit_next_s = 2'd0;
                    end else begin
                        digit_next_s  = digit_r - 2'd1;
                        timer_load_s  = 1'b1;
                        timer_value_s = SEC_LOAD;
                    end
                end else begin
                    state_next_s = COUNTDOWN;
                end
            end
            FIGHT: begin
                if (stock_out_s) begin
                    state_next_s  = GAME_OVER;
                    winner_next_s = winner_code(stocks1, stocks2);
                    timer_load_s  = 1'b1;
                    timer_value_s = GO_LOAD;
                end else if (respawn1 || respawn2) begin
                    state_next_s  = KO_PAUSE;
                    timer_load_s  = 1'b1;
                    timer_value_s = KO_LOAD;
                end else if (start_edge_s) begin
                    state_next_s = PAUSED;
                end else begin
                    state_next_s = FIGHT;
                end
            end
            PAUSED: begin
                if (start_edge_s) begin
                    state_next_s = FIGHT;
                end else begin
                    state_next_s = PAUSED;
                end
            end
            KO_PAUSE: begin
                if (stock_out_s) begin
                    state_next_s  = GAME_OVER;
                    winner_next_s = winner_code(stocks1, stocks2);
                    timer_load_s  = 1'b1;
                    timer_value_s = GO_LOAD;
                end else if (timer_zero_s) begin
                    state_next_s = FIGHT;
                end else begin
                    state_next_s = KO_PAUSE;
                end
            end
            GAME_OVER: begin
                if (start_edge_s && timer_zero_s) begin
                    state_next_s  = TITLE;
                    winner_next_s = WIN_NONE;
                end else begin
                    state_next_s = GAME_OVER;
                end
            end
            default: begin
                state_next_s  = TITLE;
                digit_next_s  = 2'd0;
                winner_next_s = WIN_NONE;
            end
        endcase
    end

    // State, output and start-history registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= TITLE;
            play_enable_r <= 1'b0;
            match_reset_r <= 1'b0;
            digit_r       <= 2'd0;
            winner_r      <= WIN_NONE;
            start1_prev_r <= 1'b1;
            start2_prev_r <= 1'b1;
        end else begin
            state_r       <= state_next_s;
            play_enable_r <= (state_next_s == FIGHT);
            match_reset_r <= match_reset_next_s;
            digit_r       <= digit_next_s;
            winner_r      <= winner_next_s;
            start1_prev_r <= start1;
            start2_prev_r <= start2;
        end
    end

    assign game_state      = state_r;
    assign play_enable     = play_enable_r;
    assign match_reset     = match_reset_r;
    assign countdown_digit = digit_r;
    assign winner          = winner_r;

endmodule
